param_mem: RTL and testbench

PARAM_MEM -- requirements
Module: param_mem

---
 rtl/param_mem.sv | 101 ++++++++++
 tb/tb_param_mem.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/param_mem.sv
// param_mem: byte-masked word memory with a configurable wait-state handshake.
// Define PARAM_MEM_BOUNDS_EN to flag out-of-range word indices instead of wrapping them.
module param_mem #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                write_enable,
    input  logic [DATA_W/8-1:0] byte_mask,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                mem_wait,
    output logic                ack,
    output logic                err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              l_we;
    logic [NB-1:0]     l_mask;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_data;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, do_access, cur_we, in_range;
    logic [NB-1:0]     cur_mask;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [IDX_W-1:0]  idx;

    // Zero-wait accesses complete on the accept edge from the live inputs
    assign accept    = state == IDLE && en;
    assign do_access = WAIT_STATES == 0 ? accept : state == WAIT && cnt == 4'd1;
    assign cur_we    = state == IDLE ? write_enable : l_we;
    assign cur_mask  = state == IDLE ? byte_mask : l_mask;
    assign cur_addr  = state == IDLE ? addr : l_addr;
    assign cur_data  = state == IDLE ? data_in : l_data;
    assign idx       = IDX_W'(cur_addr >> OFF);

`ifdef PARAM_MEM_BOUNDS_EN
    assign in_range = (cur_addr >> OFF) < ADDR_W'(DEPTH);
`else
    assign in_range = 1'b1;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= '0;
            mem_wait <= 1'b0;
            ack      <= 1'b0;
            l_we     <= 1'b0;
            l_mask   <= '0;
            l_addr   <= '0;
            l_data   <= '0;
`ifdef PARAM_MEM_BOUNDS_EN
            err      <= 1'b0;
`endif
        end else begin
            ack <= do_access;
`ifdef PARAM_MEM_BOUNDS_EN
            err <= do_access && !in_range;
`endif
            if (accept) begin
                l_we   <= write_enable;
                l_mask <= byte_mask;
                l_addr <= addr;
                l_data <= data_in;
            end
            if (do_access && cur_we && in_range)
                for (int b = 0; b < NB; b++)
                    if (cur_mask[b]) mem[idx][8*b +: 8] <= cur_data[8*b +: 8];
            if (do_access && !cur_we) data_out <= in_range ? mem[idx] : '0;
            // Counter is loaded with N and the access fires as it steps from 1 to 0
            if (accept && WAIT_STATES != 0) begin
                state    <= WAIT;
                mem_wait <= 1'b1;
                cnt      <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state    <= DONE;
                    mem_wait <= 1'b0;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_param_mem.sv
// tb_param_mem: scoreboard bench for param_mem with a 2-wait-state and a 0-wait-state instance.
module tb_param_mem;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic        en0 = 0, we0 = 0, en1 = 0, we1 = 0;
    logic [1:0]  bm0 = 0, bm1 = 0;
    logic [15:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
    logic [15:0] q0, q1;
    logic        mw0, ack0, err0, mw1, ack1, err1;

    param_mem u0 (.clk(clk), .rst(rst), .en(en0), .write_enable(we0), .byte_mask(bm0),
                  .addr(a0), .data_in(d0), .data_out(q0), .mem_wait(mw0), .ack(ack0), .err(err0));
    param_mem #(.WAIT_STATES(0)) u1 (.clk(clk), .rst(rst), .en(en1), .write_enable(we1), .byte_mask(bm1),
                  .addr(a1), .data_in(d1), .data_out(q1), .mem_wait(mw1), .ack(ack1), .err(err1));

    typedef struct {logic [15:0] d; logic e;} exp_t;
    exp_t        sb0[$], sb1[$];
    exp_t        e0, e1;
    logic [15:0] m0 [256];
    logic [15:0] m1 [256];
    logic [15:0] last0 = 0, last1 = 0;
    int          n_tests = 0, n_fail = 0, ack1_cnt = 0, mw1_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] d, input logic [1:0] m);
        return {m[1] ? d[15:8] : o[15:8], m[0] ? d[7:0] : o[7:0]};
    endfunction

    task automatic push0(input logic we, input logic [1:0] mask, input logic [15:0] addr, input logic [15:0] data);
        int   w = int'(addr >> 1);
        bit   oob;
        exp_t e;
`ifdef PARAM_MEM_BOUNDS_EN
        oob = w >= 256;
`else
        oob = 0;
`endif
        w = w % 256;
        if (we) begin
            if (!oob) m0[w] = merge(m0[w], data, mask);
        end else last0 = oob ? 16'h0 : m0[w];
        e.d = last0;
        e.e = oob;
        sb0.push_back(e);
    endtask

    task automatic push1(input logic we, input logic [15:0] addr, input logic [15:0] data);
        int   w = int'(addr >> 1) % 256;
        exp_t e;
        if (we) m1[w] = data;
        else last1 = m1[w];
        e.d = last1;
        e.e = 1'b0;
        sb1.push_back(e);
    endtask

    // One access on the wait-state instance; now=1 drives without first waiting for a fresh negedge
    task automatic acc0(input logic we, input logic [1:0] mask, input logic [15:0] addr, input logic [15:0] data,
                        input bit now, input bit toggle, input int lat);
        int k = 0, mw = 0;
        bit got = 0;
        if (!now) @(negedge clk);
        push0(we, mask, addr, data);
        en0 = 1; we0 = we; bm0 = mask; a0 = addr; d0 = data;
        while (!got && k < 12) begin
            @(negedge clk);
            k++;
            if (ack0) got = 1;
            else if (mw0) begin
                mw++;
                en0 = toggle ? 1'($urandom) : 1'b0;
                if (toggle) begin
                    a0 = 16'($urandom); d0 = 16'($urandom); we0 = 1'($urandom); bm0 = 2'($urandom);
                end
            end
        end
        en0 = 0;
        check("ack0_latency", k, lat);
        check("mem_wait0_cycles", mw, 2);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mw1) mw1_cnt++;
            if (ack0) begin
                if (sb0.size() == 0) check("ack0_extra", 1, 0);
                else begin
                    e0 = sb0.pop_front();
                    check("data_out0", q0, e0.d);
                    check("err0", err0, e0.e);
                end
            end
            if (ack1) begin
                ack1_cnt++;
                if (sb1.size() == 0) check("ack1_extra", 1, 0);
                else begin
                    e1 = sb1.pop_front();
                    check("data_out1", q1, e1.d);
                    check("err1", err1, e1.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_data_out", q0, 0);
        check("rst_mem_wait", mw0, 0);
        check("rst_ack", ack0, 0);
        check("rst_err", err0, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        acc0(1, 2'b11, 16'h1C, 16'hDDCC, 1, 0, 3);
        acc0(0, 2'b11, 16'h1C, 16'h0, 0, 0, 3);
        acc0(1, 2'b11, 16'h10, 16'h1234, 0, 0, 3);
        acc0(1, 2'b10, 16'h10, 16'hABFF, 0, 0, 3);
        acc0(0, 2'b01, 16'h10, 16'h0, 0, 0, 3);
        acc0(1, 2'b00, 16'h10, 16'hFFFF, 0, 0, 3);
        acc0(0, 2'b11, 16'h11, 16'h0, 0, 0, 3);
        acc0(0, 2'b11, 16'h1C, 16'h0, 1, 0, 4);
        acc0(1, 2'b11, 16'h00, 16'hBEEF, 0, 0, 3);
        acc0(0, 2'b11, 16'h0200, 16'h0, 0, 0, 3);
        acc0(1, 2'b11, 16'h30, 16'h7777, 0, 1, 3);
        acc0(0, 2'b11, 16'h30, 16'h0, 0, 1, 3);
        acc0(1, 2'b11, 16'h20, 16'h0F0F, 0, 0, 3);
        acc0(0, 2'b11, 16'h20, 16'h0, 0, 0, 3);
        // Abort a write mid-wait with an asynchronous reset pulse
        @(negedge clk);
        en0 = 1; we0 = 1; bm0 = 2'b11; a0 = 16'h20; d0 = 16'h5555;
        @(negedge clk);
        en0 = 0;
        check("abort_in_wait", mw0, 1);
        rst = 0;
        #1;
        check("abort_data_out", q0, 0);
        check("abort_mem_wait", mw0, 0);
        check("abort_ack", ack0, 0);
        check("abort_err", err0, 0);
        last0 = 0;
        last1 = 0;
        repeat (2) @(negedge clk);
        check("abort_ack_held", ack0, 0);
        rst = 1;
        acc0(0, 2'b11, 16'h20, 16'h0, 1, 0, 3);
        // Zero-wait instance: back-to-back accesses on consecutive cycles
        ack1_cnt = 0;
        mw1_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push1(i < 3, 16'(2 * (i % 3)), 16'(16'h1111 * (i % 3 + 1)));
            en1 = 1; we1 = i < 3; bm1 = 2'b11; a1 = 16'(2 * (i % 3)); d1 = 16'(16'h1111 * (i % 3 + 1));
        end
        @(negedge clk);
        en1 = 0;
        repeat (3) @(negedge clk);
        check("ack1_count", ack1_cnt, 6);
        check("mem_wait1_high", mw1_cnt, 0);
        check("sb0_drained", sb0.size(), 0);
        check("sb1_drained", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
